// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Fetch sequencer states and architectural widths.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem req/gnt/rvalid,
// hands instructions to decode and applies execute redirects.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            misalign_err
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_if_valid;
  logic            w_if_valid_nxt;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] w_if_instr_nxt;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] w_if_pc_nxt;
  logic            r_misalign;
  logic            w_redir;
  logic            w_redir_bad;

  assign w_redir     = redirect_valid
                     && (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid
                     && (redirect_pc[1:0] != 2'b00);

  // An accepted redirect always wins; an in-flight
  // response is then owed to DROP rather than decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (w_redir) w_pc_nxt = redirect_pc;
      end
      REQ: begin
        if (w_redir) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = imem_gnt ? DROP : REQ;
        end else if (imem_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_redir) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          w_if_instr_nxt = imem_rdata;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + XLEN'(INSTR_BYTES);
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (w_redir) begin
          w_pc_nxt       = redirect_pc;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = REQ;
        end else if (if_ready) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = REQ;
        end
      end
      DROP: begin
        if (w_redir) w_pc_nxt = redirect_pc;
        if (imem_rvalid) w_state_nxt = REQ;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_misalign <= w_redir_bad;
    end
  end

  assign imem_req     = (r_state == REQ);
  assign imem_addr    = r_pc;
  assign if_valid     = r_if_valid;
  assign if_instr     = r_if_instr;
  assign if_pc        = r_if_pc;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run
// against a decode-stream reference model.
module tb_fetch_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .misalign_err   (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // grant now, respond next cycle; leaves the DUT holding data
  task automatic fetch_to_hold(input logic [31:0] data);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr);
    else n_pass++;
    n_checks++;
    if (if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if_valid);
    else n_pass++;
    n_checks++;
    if (if_instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", if_instr);
    else n_pass++;
    n_checks++;
    if (if_pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", if_pc);
    else n_pass++;
    n_checks++;
    if (misalign_err !== 1'b0) $display("FAIL rst_err got %b exp 0", misalign_err);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL rst_first_req got %b exp 1", imem_req);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a)
        $display("FAIL seq_req got %b/%h exp 1/%h", imem_req, imem_addr, a);
      else n_pass++;
      fetch_to_hold(mem_word(a));
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== a)
        $display("FAIL seq_out got %b/%h exp 1/%h", if_valid, if_pc, a);
      else n_pass++;
      n_checks++;
      if (if_instr !== mem_word(a))
        $display("FAIL seq_instr got %h exp %h", if_instr, mem_word(a));
      else n_pass++;
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0;
      n_checks++;
      if (if_valid !== 1'b0) $display("FAIL seq_drop got %b exp 0", if_valid);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    n_checks++;
    if (imem_addr !== 32'hC) $display("FAIL stall_addr got %h exp c", imem_addr);
    else n_pass++;
    fetch_to_hold(32'h0050_0093);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (if_valid !== 1'b1 || if_instr !== 32'h0050_0093 || if_pc !== 32'hC)
        $display("FAIL stall_hold got %b/%h/%h exp 1/00500093/c",
                 if_valid, if_instr, if_pc);
      else n_pass++;
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL stall_req got %b exp 0", imem_req);
      else n_pass++;
      tick();
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0)
      $display("FAIL stall_next got %b/%h/%b exp 1/10/0",
               imem_req, imem_addr, if_valid);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL rw_drop got %b/%b exp 0/0", if_valid, imem_req);
      else n_pass++;
      if (k == 0) tick();
    end
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL rw_next got %b/%b/%h exp 0/1/100",
               if_valid, imem_req, imem_addr);
    else n_pass++;
    fetch_to_hold(mem_word(32'h100));
    n_checks++;
    if (if_pc !== 32'h100 || if_instr !== mem_word(32'h100))
      $display("FAIL rw_pc got %h/%h exp 100/%h",
               if_pc, if_instr, mem_word(32'h100));
    else n_pass++;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    fetch_to_hold(mem_word(32'h104));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL rh_next got %b/%b/%h exp 0/1/40",
               if_valid, imem_req, imem_addr);
    else n_pass++;
    fetch_to_hold(mem_word(32'h40));
    n_checks++;
    if (if_pc !== 32'h40) $display("FAIL rh_pc got %h exp 40", if_pc);
    else n_pass++;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h44)
      $display("FAIL mis_pulse got %b/%b/%h exp 1/1/44",
               misalign_err, imem_req, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (misalign_err !== 1'b0 || imem_addr !== 32'h44)
      $display("FAIL mis_clear got %b/%h exp 0/44", misalign_err, imem_addr);
    else n_pass++;
    fetch_to_hold(mem_word(32'h44));
    n_checks++;
    if (if_pc !== 32'h44 || if_instr !== mem_word(32'h44))
      $display("FAIL mis_fetch got %h/%h exp 44/%h",
               if_pc, if_instr, mem_word(32'h44));
    else n_pass++;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr got %b/%h exp 1/fffffffc", imem_req, imem_addr);
    else n_pass++;
    fetch_to_hold(mem_word(32'hFFFF_FFFC));
    n_checks++;
    if (if_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_pc got %h exp fffffffc", if_pc);
    else n_pass++;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || misalign_err !== 1'b0)
      $display("FAIL wrap_next got %b/%h/%b exp 1/0/0",
               imem_req, imem_addr, misalign_err);
    else n_pass++;
  endtask

  task automatic test_reset_midfetch();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0)
      $display("FAIL rmid_async got %h/%b exp 0/0", imem_addr, if_valid);
    else n_pass++;
    tick();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h200);
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0)
      $display("FAIL rmid_req got %b/%h/%b exp 1/0/0",
               imem_req, imem_addr, if_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL rmid_ign got %b/%b exp 1/0", imem_req, if_valid);
    else n_pass++;
    fetch_to_hold(mem_word(32'h0));
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== mem_word(32'h0))
      $display("FAIL rmid_fetch got %h/%h exp 0/%h",
               if_pc, if_instr, mem_word(32'h0));
    else n_pass++;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  // Model: m_pc is the address of the next new instruction decode
  // should see; accepted ones advance it, aligned redirects replace it.
  task automatic test_random();
    logic [31:0] m_pc = '0;
    logic [31:0] h_pc = '0;
    logic [31:0] h_instr = '0;
    logic [31:0] p_addr = '0;
    logic [31:0] tgt;
    logic        m_hold = 1'b0;
    logic        m_err = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    int          delivered = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      n_checks++;
      if (misalign_err !== m_err)
        $display("FAIL rnd_err c=%0d got %b exp %b", c, misalign_err, m_err);
      else n_pass++;
      if (m_hold) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== h_pc || if_instr !== h_instr)
          $display("FAIL rnd_hold c=%0d got %b/%h/%h exp 1/%h/%h",
                   c, if_valid, if_pc, if_instr, h_pc, h_instr);
        else n_pass++;
      end else if (if_valid) begin
        delivered++;
        n_checks++;
        if (if_pc !== m_pc || if_instr !== mem_word(m_pc))
          $display("FAIL rnd_instr c=%0d got %h/%h exp %h/%h",
                   c, if_pc, if_instr, m_pc, mem_word(m_pc));
        else n_pass++;
      end
      if (imem_req) begin
        n_checks++;
        if (imem_addr !== m_pc)
          $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, m_pc);
        else n_pass++;
      end
      imem_rvalid    = pend && (cnt == 0);
      imem_rdata     = imem_rvalid ? mem_word(p_addr) : $urandom;
      imem_gnt       = imem_req && !pend && ($urandom_range(0, 1) == 1);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      tgt            = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      redirect_pc    = tgt;
      m_err = redirect_valid && (tgt[1:0] != 2'b00);
      if (redirect_valid && tgt[1:0] == 2'b00) begin
        m_pc   = tgt;
        m_hold = 1'b0;
      end else if (if_valid && if_ready) begin
        m_pc   = m_pc + 32'd4;
        m_hold = 1'b0;
      end else if (if_valid) begin
        m_hold  = 1'b1;
        h_pc    = if_pc;
        h_instr = if_instr;
      end else begin
        m_hold = 1'b0;
      end
      if (imem_rvalid) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_gnt) begin
        pend   = 1'b1;
        p_addr = imem_addr;
        cnt    = $urandom_range(0, 2);
      end
      tick();
    end
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    n_checks++;
    if (delivered < 50)
      $display("FAIL rnd_progress got %0d exp >=50", delivered);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
